// File: rtl/spi_frame_sequencer.sv
// Round-robin SPI master: two requesters share one 9-bit LSB-first frame link (mode 0).
// Each frame: one SETUP half-period, then a HIGH/LOW sck pair per bit, then back to IDLE.
module spi_frame_sequencer #(
    parameter int FRAME_BITS = 9,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [FRAME_BITS-1:0] data0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic [FRAME_BITS-1:0] data1,
    output logic                  gnt1,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  cs_n,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(FRAME_BITS) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t                state;
    logic                  ptr;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] rx_shift;
    logic                  div_end;
    logic                  pick1;
    logic [FRAME_BITS-1:0] win_data;

    // ptr=1 means requester 1 wins a tie
    assign div_end  = (div_cnt == DIV_LAST);
    assign pick1    = req1 && (!req0 || ptr);
    assign win_data = pick1 ? data1 : data0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs_n     <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            if (state != IDLE) begin
                div_cnt <= div_end ? '0 : div_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (req0 || req1) begin
                        tx_shift <= win_data >> 1;
                        mosi     <= win_data[0];
                        ptr      <= ~pick1;
                        gnt0     <= ~pick1;
                        gnt1     <= pick1;
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        sck   <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (div_end) begin
                        rx_shift <= {miso, rx_shift[FRAME_BITS-1:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        sck      <= 1'b0;
                        mosi     <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (div_end) begin
                        if (bit_cnt != BIT_LAST) begin
                            sck   <= 1'b1;
                            state <= HIGH;
                        end else begin
                            cs_n    <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            rx_data <= rx_shift;
                            mosi    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer: a CLK_DIV=4 instance and a CLK_DIV=1 instance,
// with a queue of expected grant owners and received frames popped at each done.
module tb_spi_frame_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Slow (CLK_DIV=4) instance
    logic       s_req0 = 1'b0, s_req1 = 1'b0;
    logic [8:0] s_data0 = '0, s_data1 = '0;
    logic       s_gnt0, s_gnt1, s_busy, s_done, s_cs_n, s_sck, s_mosi, s_miso;
    logic [8:0] s_rx_data;

    // Fast (CLK_DIV=1) instance
    logic       f_req0 = 1'b0, f_req1 = 1'b0;
    logic [8:0] f_data0 = '0, f_data1 = '0;
    logic       f_gnt0, f_gnt1, f_busy, f_done, f_cs_n, f_sck, f_mosi, f_miso;
    logic [8:0] f_rx_data;

    spi_frame_sequencer #(.FRAME_BITS(9), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .req0(s_req0), .data0(s_data0), .gnt0(s_gnt0),
        .req1(s_req1), .data1(s_data1), .gnt1(s_gnt1),
        .busy(s_busy), .done(s_done), .rx_data(s_rx_data),
        .cs_n(s_cs_n), .sck(s_sck), .mosi(s_mosi), .miso(s_miso)
    );

    spi_frame_sequencer #(.FRAME_BITS(9), .CLK_DIV(1)) dut_fast (
        .clk(clk), .rst(rst),
        .req0(f_req0), .data0(f_data0), .gnt0(f_gnt0),
        .req1(f_req1), .data1(f_data1), .gnt1(f_gnt1),
        .busy(f_busy), .done(f_done), .rx_data(f_rx_data),
        .cs_n(f_cs_n), .sck(f_sck), .mosi(f_mosi), .miso(f_miso)
    );

    // miso source: loopback of mosi, or a slave model returning model_word LSB-first
    logic       use_model = 1'b0;
    logic [8:0] model_word = '0;
    int         model_idx = 0;
    logic       sck_q = 1'b0;
    logic       model_bit;
    always @(posedge clk) begin
        sck_q <= s_sck;
        if (s_cs_n) model_idx <= 0;
        else if (sck_q && !s_sck) model_idx <= model_idx + 1;
    end
    assign model_bit = (model_idx < 9) ? model_word[model_idx] : 1'b0;
    assign s_miso    = use_model ? model_bit : s_mosi;
    assign f_miso    = f_mosi;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation mux selecting which instance the frame monitor watches
    logic       sel_fast = 1'b0;
    logic       o_gnt0, o_gnt1, o_busy, o_done, o_cs_n, o_sck, o_mosi;
    logic [8:0] o_rx_data;
    assign o_gnt0    = sel_fast ? f_gnt0    : s_gnt0;
    assign o_gnt1    = sel_fast ? f_gnt1    : s_gnt1;
    assign o_busy    = sel_fast ? f_busy    : s_busy;
    assign o_done    = sel_fast ? f_done    : s_done;
    assign o_cs_n    = sel_fast ? f_cs_n    : s_cs_n;
    assign o_sck     = sel_fast ? f_sck     : s_sck;
    assign o_mosi    = sel_fast ? f_mosi    : s_mosi;
    assign o_rx_data = sel_fast ? f_rx_data : s_rx_data;

    int n_checks = 0;
    int n_pass   = 0;

    int         exp_gnt[$];
    logic [8:0] exp_rx[$];

    // Per-frame observations
    int          fr_gnt_cnt, fr_gnt_id, fr_gnt_time, fr_cs_low, fr_rises, fr_max_run, fr_done_time;
    logic [15:0] fr_mosi_word;
    bit          fr_mosi_one, fr_done, fr_busy_gnt, fr_cs_at_done, fr_busy_done;
    int          prev_done_time;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic rq0, input logic rq1, input logic [8:0] d0, input logic [8:0] d1);
        s_req0  = rq0;
        s_req1  = rq1;
        s_data0 = d0;
        s_data1 = d1;
    endtask

    task automatic expectFrame(input int owner, input logic [8:0] rx);
        exp_gnt.push_back(owner);
        exp_rx.push_back(rx);
    endtask

    // Follows one frame from before its grant to its done pulse
    task automatic waitFrame(input int limit, input bit drop_on_gnt);
        int run;
        bit prev_sck, prev_low;
        fr_gnt_cnt = 0; fr_gnt_id = -1; fr_gnt_time = 0; fr_cs_low = 0; fr_rises = 0;
        fr_max_run = 0; fr_done_time = 0; fr_mosi_word = '0; fr_mosi_one = 0; fr_done = 0;
        fr_busy_gnt = 0; fr_cs_at_done = 0; fr_busy_done = 1;
        run = 0; prev_sck = o_sck; prev_low = 0;
        for (int i = 0; i < limit && !fr_done; i++) begin
            @(negedge clk);
            if (o_gnt0 || o_gnt1) begin
                fr_gnt_cnt++;
                fr_gnt_id   = o_gnt1 ? 1 : 0;
                fr_gnt_time = cyc;
                fr_busy_gnt = o_busy;
                if (drop_on_gnt) begin
                    s_req0 = 1'b0;
                    s_req1 = 1'b0;
                end
            end
            if (!o_cs_n) begin
                fr_cs_low++;
                if (o_mosi) fr_mosi_one = 1;
                run = (prev_low && o_sck == prev_sck) ? run + 1 : 1;
                if (run > fr_max_run) fr_max_run = run;
            end
            if (o_sck && !prev_sck) begin
                if (fr_rises < 16) fr_mosi_word[fr_rises] = o_mosi;
                fr_rises++;
            end
            if (o_done) begin
                fr_done       = 1;
                fr_done_time  = cyc;
                fr_cs_at_done = o_cs_n;
                fr_busy_done  = o_busy;
            end
            prev_sck = o_sck;
            prev_low = !o_cs_n;
        end
        checkOutput("frame_done_seen", 32'(fr_done), 1);
    endtask

    // Scoreboard pop plus the checks common to every frame
    task automatic checkFrame();
        checkOutput("gnt_count", fr_gnt_cnt, 1);
        checkOutput("busy_at_gnt", 32'(fr_busy_gnt), 1);
        checkOutput("cs_n_at_done", 32'(fr_cs_at_done), 1);
        checkOutput("busy_at_done", 32'(fr_busy_done), 0);
        if (exp_gnt.size() == 0) checkOutput("scoreboard_underflow", 1, 0);
        else begin
            checkOutput("gnt_owner", fr_gnt_id, exp_gnt.pop_front());
            checkOutput("rx_data", 32'(o_rx_data), 32'(exp_rx.pop_front()));
        end
    endtask

    initial begin
        // Reset with both requesters pending
        applyStimulus(1'b1, 1'b1, 9'h1A5, 9'h0AA);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_no_gnt", {30'd0, s_gnt1, s_gnt0}, 0);
        end
        checkOutput("reset_cs_n", 32'(s_cs_n), 1);
        checkOutput("reset_sck", 32'(s_sck), 0);
        checkOutput("reset_mosi", 32'(s_mosi), 0);
        checkOutput("reset_busy", 32'(s_busy), 0);
        checkOutput("reset_done", 32'(s_done), 0);
        checkOutput("reset_rx_data", 32'(s_rx_data), 0);

        // Single frame, loopback
        applyStimulus(1'b1, 1'b0, 9'h1A5, 9'h0AA);
        expectFrame(0, 9'h1A5);
        rst = 1'b0;
        waitFrame(300, 1'b1);
        checkFrame();
        checkOutput("loop_cs_low", fr_cs_low, 76);
        checkOutput("loop_rises", fr_rises, 9);
        checkOutput("loop_mosi_bits", 32'(fr_mosi_word), 32'h1A5);
        checkOutput("loop_half_period", fr_max_run, 4);
        @(negedge clk);
        checkOutput("loop_done_one_cycle", 32'(s_done), 0);
        repeat (4) @(negedge clk);
        checkOutput("loop_no_regrant", 32'(s_busy), 0);

        // Independent receive from slave model
        use_model  = 1'b1;
        model_word = 9'h0F3;
        applyStimulus(1'b1, 1'b0, 9'h000, 9'h000);
        expectFrame(0, 9'h0F3);
        waitFrame(300, 1'b1);
        checkFrame();
        checkOutput("rx_mosi_quiet", 32'(fr_mosi_one), 0);
        checkOutput("rx_rises", fr_rises, 9);
        use_model = 1'b0;
        repeat (3) @(negedge clk);

        // Reset on the 5th rising sck, then the pending req0 is re-granted
        applyStimulus(1'b1, 1'b0, 9'h0C3, 9'h000);
        begin
            int  rises;
            bit  psck;
            rises = 0;
            psck  = s_sck;
            for (int i = 0; i < 300 && rises < 5; i++) begin
                @(negedge clk);
                if (s_sck && !psck) rises++;
                psck = s_sck;
            end
            checkOutput("midreset_reached_5th_rise", rises, 5);
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_cs_n", 32'(s_cs_n), 1);
        checkOutput("midreset_sck", 32'(s_sck), 0);
        checkOutput("midreset_no_done", 32'(s_done), 0);
        checkOutput("midreset_no_gnt", {30'd0, s_gnt1, s_gnt0}, 0);
        checkOutput("midreset_busy", 32'(s_busy), 0);
        rst = 1'b0;
        expectFrame(0, 9'h0C3);
        waitFrame(300, 1'b1);
        checkFrame();
        checkOutput("midreset_cs_low", fr_cs_low, 76);
        checkOutput("midreset_mosi_bits", 32'(fr_mosi_word), 32'h0C3);

        // Fairness with both requests held from reset
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 9'h001, 9'h100);
        repeat (2) @(negedge clk);
        expectFrame(0, 9'h001);
        expectFrame(1, 9'h100);
        expectFrame(0, 9'h001);
        expectFrame(1, 9'h100);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waitFrame(300, 1'b0);
            if (k == 3) applyStimulus(1'b0, 1'b0, 9'h001, 9'h100);
            checkFrame();
            if (k > 0) checkOutput("fair_gnt_after_done", fr_gnt_time - prev_done_time, 1);
            prev_done_time = fr_done_time;
        end
        repeat (4) @(negedge clk);
        checkOutput("fair_idle_after", 32'(s_busy), 0);

        // Minimum divider: req1 held for three frames
        sel_fast = 1'b1;
        f_data1  = 9'h16B;
        f_req1   = 1'b1;
        for (int k = 0; k < 3; k++) expectFrame(1, 9'h16B);
        for (int k = 0; k < 3; k++) begin
            waitFrame(100, 1'b0);
            if (k == 2) f_req1 = 1'b0;
            checkFrame();
            checkOutput("fast_cs_low", fr_cs_low, 19);
            checkOutput("fast_sck_every_cycle", fr_max_run, 1);
            checkOutput("fast_rises", fr_rises, 9);
            if (k > 0) checkOutput("fast_done_spacing", fr_done_time - prev_done_time, 20);
            prev_done_time = fr_done_time;
        end
        repeat (3) @(negedge clk);
        checkOutput("fast_idle_after", 32'(f_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
